// File: rtl/axil_cfg_pkg.sv
// axil_cfg_pkg: FSM states, AXI4-Lite response codes and filter register offsets for axil_cfg_master
package axil_cfg_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;
  localparam logic [31:0] REG_CTRL        = 32'h00;
  localparam logic [31:0] REG_PKT_IN      = 32'h04;
  localparam logic [31:0] REG_PKT_PASS    = 32'h08;
  localparam logic [31:0] REG_PKT_DROP    = 32'h0C;
  localparam logic [31:0] REG_RULE0_0     = 32'h10;
  localparam logic [31:0] REG_RULE0_1     = 32'h14;
  localparam logic [31:0] REG_RULE0_2     = 32'h18;
  localparam logic [31:0] REG_RULE1_0     = 32'h20;
  localparam logic [31:0] REG_RULE1_1     = 32'h24;
  localparam logic [31:0] REG_RULE1_2     = 32'h28;
  localparam logic [31:0] REG_PRINT_CTRL  = 32'h30;
  localparam logic [31:0] REG_SOFT_RESET  = 32'h40;
endpackage

// File: rtl/axil_cfg_master.sv
// axil_cfg_master: one-outstanding AXI4-Lite initiator, command in / response out; AXIL_MASTER_TIMEOUT_EN adds a timeout abort
module axil_cfg_master
  import axil_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_axil,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        m_axil_awvalid,
  output logic [31:0] m_axil_awaddr,
  input  logic        m_axil_awready,
  output logic        m_axil_wvalid,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  input  logic        m_axil_wready,
  input  logic        m_axil_bvalid,
  input  logic [1:0]  m_axil_bresp,
  output logic        m_axil_bready,
  output logic        m_axil_arvalid,
  output logic [31:0] m_axil_araddr,
  input  logic        m_axil_arready,
  input  logic        m_axil_rvalid,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  output logic        m_axil_rready
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end
  state_t state;
  logic hs, tmo;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign hs = state == WR_REQ  ? (!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready) :
              state == WR_RESP ? m_axil_bvalid :
              state == RD_REQ  ? m_axil_arready :
              state == RD_RESP ? m_axil_rvalid : 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = cnt == 16'(TIMEOUT_CYCLES) && state != RSP;
  always_ff @(posedge clk_axil)
    if (rst || state == IDLE || state == RSP) cnt <= '0;
    else cnt <= cnt + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_axil) begin
    if (rst) begin
      state <= IDLE;
      m_axil_awvalid <= 1'b0;
      m_axil_awaddr <= '0;
      m_axil_wvalid <= 1'b0;
      m_axil_wdata <= '0;
      m_axil_wstrb <= '0;
      m_axil_bready <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_araddr <= '0;
      m_axil_rready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      rsp_timeout <= 1'b0;
    end else if (tmo && !hs) begin
      state <= RSP;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid <= 1'b0;
      m_axil_bready <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready <= 1'b0;
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_resp <= AXIL_RESP_SLVERR;
      rsp_timeout <= 1'b1;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state <= cmd_write ? WR_REQ : RD_REQ;
          m_axil_awvalid <= cmd_write;
          m_axil_wvalid <= cmd_write;
          m_axil_arvalid <= !cmd_write;
          if (cmd_write) begin
            m_axil_awaddr <= cmd_addr;
            m_axil_wdata <= cmd_wdata;
            m_axil_wstrb <= cmd_wstrb;
          end else m_axil_araddr <= cmd_addr;
        end
        WR_REQ: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if (hs) begin
            state <= WR_RESP;
            m_axil_bready <= 1'b1;
          end
        end
        WR_RESP: if (hs) begin
          state <= RSP;
          m_axil_bready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_resp <= m_axil_bresp;
          rsp_timeout <= 1'b0;
        end
        RD_REQ: if (hs) begin
          state <= RD_RESP;
          m_axil_arvalid <= 1'b0;
          m_axil_rready <= 1'b1;
        end
        RD_RESP: if (hs) begin
          state <= RSP;
          m_axil_rready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= m_axil_rdata;
          rsp_resp <= m_axil_rresp;
          rsp_timeout <= 1'b0;
        end
        RSP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axil_cfg_master.md
# axil_cfg_master

AXI4-Lite initiator that turns single-word command requests into one AXI4-Lite write or read transaction, and returns the result on a response channel. Sits on the 125 MHz `clk_axil` domain and drives the filter register file's AXI4-Lite slave port. Used for rule loading, statistics polling and soft reset from on-chip control logic or a test sequencer. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: abort threshold in cycles. Range 2..65535. Used only with `AXIL_MASTER_TIMEOUT_EN`.

Ports:
- `clk_axil` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32, `cmd_wstrb` in 4: write data and strobes. Ignored on reads.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP as received, or 2'b10 on timeout.
- `rsp_timeout` out 1: response was produced by a timeout abort.
- `busy` out 1: state is not IDLE.
- `m_axil_awvalid` out 1, `m_axil_awaddr` out 32, `m_axil_awready` in 1.
- `m_axil_wvalid` out 1, `m_axil_wdata` out 32, `m_axil_wstrb` out 4, `m_axil_wready` in 1.
- `m_axil_bvalid` in 1, `m_axil_bresp` in 2, `m_axil_bready` out 1.
- `m_axil_arvalid` out 1, `m_axil_araddr` out 32, `m_axil_arready` in 1.
- `m_axil_rvalid` in 1, `m_axil_rdata` in 32, `m_axil_rresp` in 2, `m_axil_rready` out 1.

## Operation
States:
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch the command. Go to WR_REQ if `cmd_write`, otherwise RD_REQ.
- WR_REQ: `awvalid` and `wvalid` are asserted together. Each drops independently after its own handshake. Once both handshakes are done (same or different cycles), go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp` and go to RSP.
- RD_REQ: `arvalid`=1 until `arready`, then go to RD_RESP.
- RD_RESP: `rready`=1. On `rvalid`, capture `rdata` and `rresp` and go to RSP.
- RSP: `rsp_valid`=1. Outputs are held stable until `rsp_ready`, then go to IDLE.

Rules:
- Address, data and strobe outputs are held stable while their valid is high.
- A/W/AR valids never depend combinationally on the matching ready.
- All outputs are registered, except `cmd_ready` and `busy`, which decode the state register.
- Reset: state IDLE; all valid and ready outputs 0; `rsp_rdata`=0, `rsp_resp`=0, `rsp_timeout`=0; address/data outputs 0.
- Reset during a transaction: the next edge returns every output to its reset value. No response is produced for the in-flight command.

## Timing
- Command accepted at edge T (write):
  - `awvalid`/`wvalid` high in cycle T+1.
  - With zero-wait slave: `bready` high in T+2, `rsp_valid` in T+3.
- Command accepted at edge T (read):
  - `arvalid` in T+1, `rready` in T+2, `rsp_valid` in T+3.
- Each ready stall on AW, W or AR adds one cycle per stalled cycle.
- Back-to-back commands: the next command is accepted one cycle after the `rsp_ready` handshake. Minimum period is 4 cycles.
- A `bvalid` present before both AW and W handshakes are done is not accepted until WR_RESP.

## Configuration
- `AXIL_MASTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the count reaches `TIMEOUT_CYCLES`, the next edge deasserts all AXI valids and readies and enters RSP with `rsp_resp`=2'b10, `rsp_timeout`=1, `rsp_rdata`=0.
  - This abort is a deliberate protocol violation, used for debug recovery only.
  - A handshake completing in the same cycle as the threshold wins over the timeout.
- Undefined: no counter, `rsp_timeout` tied 0, and the block waits indefinitely.

## Structure
- Package `axil_cfg_pkg`:
  - State enum.
  - Response constants `AXIL_RESP_OKAY`=2'b00, `AXIL_RESP_SLVERR`=2'b10, `AXIL_RESP_DECERR`=2'b11.
  - Register offset constants: CTRL 0x00, PKT_IN 0x04, PKT_PASS 0x08, PKT_DROP 0x0C, RULE0 0x10/0x14/0x18, RULE1 0x20/0x24/0x28, PRINT_CTRL 0x30, SOFT_RESET 0x40.
- Single module, no sub-modules.

## Test plan
- Write 0x14 ← 0xDEAD_BEEF to a zero-wait slave:
  - `awaddr`=0x14, `wdata`=0xDEAD_BEEF, `wstrb`=0xF in T+1.
  - `rsp_valid` in T+3 with `rsp_resp`=00 and `rsp_rdata`=0.
- Read 0x14 back after that write:
  - `rsp_rdata`=0xDEAD_BEEF, `rsp_resp`=00, `rsp_valid` in T+3.
- Write with `awready` delayed 5 cycles and `wready` immediate:
  - `wvalid` drops after 1 cycle; `awvalid` is held for 6 cycles.
  - `bready` only after both handshakes; response still OKAY.
- Slave returns `rresp`=2'b11 and `rdata`=0x1234:
  - `rsp_resp`=11, `rsp_rdata`=0x1234, `rsp_timeout`=0.
- `rsp_ready` held low for 10 cycles:
  - `rsp_valid`/`rsp_rdata` stable throughout; `cmd_ready` stays 0 until the cycle after the handshake.
- Macro on, `TIMEOUT_CYCLES`=16, `arready` never asserted:
  - After 16 cycles `arvalid` drops; response 2'b10 with `rsp_timeout`=1.
  - Separately: `rst` asserted mid-write returns all outputs to reset values at the next edge, with no response.
